spi_master_slave: RTL and testbench

//  Point-to-point SPI link in one clock domain: master serialises a DATA_WIDTH word on

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_master_slave_if.sv | 29 ++
 rtl/spi_slave_rx.sv | 71 +++++++
 rtl/spi_master_slave.sv | 111 +++++++++++
 tb/tb_spi_master_slave.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared defaults and FSM encoding for the single-domain SPI master/slave link.
package spi_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 4;
  localparam int CNT_W          = $clog2(DEF_DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_master_slave_if.sv
// Parallel-side bundle of the SPI link: frame request, transmit word, serial lines and receive results.
interface spi_master_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  start;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  miso;
  logic                  mosi;
  logic                  sclk;
  logic                  ss_n;
  logic                  finish;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  r_finish;

  // master: the link itself; slave: the client that requests frames and reads results
  modport master (
    input  start, data_i, miso,
    output mosi, sclk, ss_n, finish, data_o, r_finish
  );

  modport slave (
    output start, data_i, miso,
    input  mosi, sclk, ss_n, finish, data_o, r_finish
  );

endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receiver: synchronises sclk/mosi/ss_n, shifts MSB-first on sclk rises, publishes full words.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mosi,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  start,
  input  logic                  tx_finish,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  r_finish
);

  localparam int              CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH - 1);

  logic                  sclk_p0, sclk_p1, sclk_p2;
  logic                  mosi_p0, mosi_p1;
  logic                  ss_n_p0, ss_n_p1;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-2:0] sr;
  logic                  rise;

  assign rise = sclk_p1 & ~sclk_p2 & ~ss_n_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0  <= 1'b0;
      sclk_p1  <= 1'b0;
      sclk_p2  <= 1'b0;
      mosi_p0  <= 1'b0;
      mosi_p1  <= 1'b0;
      ss_n_p0  <= 1'b1;
      ss_n_p1  <= 1'b1;
      cnt      <= '0;
      sr       <= '0;
      data_o   <= '0;
      r_finish <= 1'b0;
    end else begin
      // p0/p1: two-flop synchronisers; p2: previous synced sclk for edge detection
      sclk_p0  <= sclk;
      sclk_p1  <= sclk_p0;
      sclk_p2  <= sclk_p1;
      mosi_p0  <= mosi;
      mosi_p1  <= mosi_p0;
      ss_n_p0  <= ss_n;
      ss_n_p1  <= ss_n_p0;
      r_finish <= 1'b0;
      // Any re-arm source throws away a partial word; data_o keeps the last good one
      if (start || tx_finish || ss_n_p1) begin
        cnt <= '0;
        sr  <= '0;
      end else if (rise) begin
        if (cnt == CNT_LAST) begin
          data_o   <= {sr, mosi_p1};
          r_finish <= 1'b1;
          cnt      <= '0;
          sr       <= '0;
        end else begin
          sr  <= (DATA_WIDTH-1)'({sr, mosi_p1});
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_master_slave.sv
// SPI mode-0 master (divider, FSM, tx shifter) looped into an on-chip receiver in the same clock domain.
module spi_master_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input logic               clk,
  input logic               rst_n,
  spi_master_slave_if.master bus
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam int               TOG_W    = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_WIDTH - 1);

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [TOG_W-1:0]      tog_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] miso_unused;
  logic                  mosi_q, sclk_q, ss_n_q, finish_q;
  logic                  accept, tick, rx_start;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_done;

  assign accept   = (state == IDLE) && bus.start;
  assign tick     = (state == SHIFT) && (div_cnt == DIV_LAST);
  // Only an accepted start re-arms the receiver, so a start ignored mid-frame cannot corrupt it
  assign rx_start = accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      tog_cnt  <= '0;
      mosi_q   <= 1'b0;
      sclk_q   <= 1'b0;
      ss_n_q   <= 1'b1;
      finish_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            ss_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= bus.data_i[DATA_WIDTH-1];
            div_cnt <= '0;
            tog_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
            tog_cnt <= tog_cnt + 1'b1;
            if (tog_cnt == TOG_LAST) begin
              ss_n_q   <= 1'b1;
              finish_q <= 1'b1;
              mosi_q   <= 1'b0;
              state    <= DONE;
            end else if (sclk_q) begin
              mosi_q <= tx_sr[DATA_WIDTH-2];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // tx word and the reserved miso capture are pure datapath; their contents are don't-care outside a frame
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr <= bus.data_i;
    end else if (tick && sclk_q) begin
      tx_sr <= tx_sr << 1;
    end
    if (tick && !sclk_q) begin
      miso_unused <= {miso_unused[DATA_WIDTH-2:0], bus.miso};
    end
  end

  spi_slave_rx #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .mosi     (mosi_q),
    .sclk     (sclk_q),
    .ss_n     (ss_n_q),
    .start    (rx_start),
    .tx_finish(finish_q),
    .data_o   (rx_data),
    .r_finish (rx_done)
  );

  assign bus.mosi     = mosi_q;
  assign bus.sclk     = sclk_q;
  assign bus.ss_n     = ss_n_q;
  assign bus.finish   = finish_q;
  assign bus.data_o   = rx_data;
  assign bus.r_finish = rx_done;

endmodule

// File: tb/tb_spi_master_slave.sv
// Self-checking bench for spi_master_slave: random words against a frame-level model of the link.
module tb_spi_master_slave;
  import spi_pkg::*;

  localparam int W         = DEF_DATA_WIDTH;
  localparam int DIV       = DEF_CLK_DIV;
  localparam int FRAME_LEN = 2 * W * DIV + 1;
  localparam int SS_LOW    = 2 * W * DIV;

  typedef struct {
    int           len;
    int           fin_w;
    int           rf_cnt;
    int           rf_cyc;
    int           last_rise;
    int           nrise;
    int           ss_low;
    logic [W-1:0] bits;
    bit           timeout;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_slave_if #(.DATA_WIDTH(W)) bus ();

  spi_master_slave #(.DATA_WIDTH(W), .CLK_DIV(DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_word;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  // mode 0: plain frame; 1: top-level start with 0xA5 at poke_at; 2: force receiver re-arm at poke_at
  task automatic do_frame(input logic [W-1:0] d, input int mode, input int poke_at, output frame_t r);
    logic prev_sclk;
    int   cyc;
    r = '{default: 0};
    bus.data_i = d;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.data_i = W'($urandom);
    prev_sclk  = 1'b0;
    cyc        = 1;
    while (1) begin
      if (bus.sclk && !prev_sclk) begin
        r.bits      = {r.bits[W-2:0], bus.mosi};
        r.nrise     = r.nrise + 1;
        r.last_rise = cyc;
      end
      prev_sclk = bus.sclk;
      if (!bus.ss_n) r.ss_low = r.ss_low + 1;
      if (bus.r_finish) begin
        r.rf_cnt = r.rf_cnt + 1;
        r.rf_cyc = cyc;
      end
      if (bus.finish) begin
        r.fin_w = r.fin_w + 1;
        if (r.len == 0) r.len = cyc;
      end
      if (r.len != 0 && !bus.finish) break;
      if (cyc >= 4 * FRAME_LEN) begin
        r.timeout = 1'b1;
        break;
      end
      if (cyc == poke_at) begin
        if (mode == 1) begin
          bus.start  = 1'b1;
          bus.data_i = W'(8'hA5);
        end else if (mode == 2) begin
          force dut.rx_start = 1'b1;
        end
      end
      if (cyc == poke_at + 1) begin
        bus.start = 1'b0;
        if (mode == 2) release dut.rx_start;
      end
      bus.miso = 1'($urandom);
      @(negedge clk);
      cyc = cyc + 1;
    end
    bus.start = 1'b0;
    if (mode == 2) release dut.rx_start;
  endtask

  task automatic test_reset();
    logic [W+4:0] got, exp;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.data_i = '0;
    bus.miso   = 1'b0;
    repeat (3) @(negedge clk);
    got = {bus.mosi, bus.sclk, bus.ss_n, bus.finish, bus.r_finish, bus.data_o};
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {W{1'b0}}};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected %b", got, exp);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.mosi, bus.sclk, bus.ss_n, bus.finish, bus.r_finish, bus.data_o};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b, expected %b", got, exp);
    end
    last_word = '0;
  endtask

  task automatic test_basic_frame();
    frame_t       r;
    logic [W-1:0] d = W'(8'h35);
    do_frame(d, 0, 0, r);
    n_checks++;
    if (r.timeout) begin n_fail++; $display("FAIL basic_timeout: no finish within %0d cycles", 4 * FRAME_LEN); end
    n_checks++;
    if (r.bits !== d) begin n_fail++; $display("FAIL basic_mosi_bits: got %h, expected %h", r.bits, d); end
    n_checks++;
    if (r.nrise != W) begin n_fail++; $display("FAIL basic_sclk_rises: got %0d, expected %0d", r.nrise, W); end
    n_checks++;
    if (r.ss_low != SS_LOW) begin n_fail++; $display("FAIL basic_ss_low: got %0d cycles, expected %0d", r.ss_low, SS_LOW); end
    n_checks++;
    if (r.fin_w != 1) begin n_fail++; $display("FAIL basic_finish_width: got %0d, expected 1", r.fin_w); end
    n_checks++;
    if (r.len != FRAME_LEN) begin n_fail++; $display("FAIL basic_frame_len: got %0d, expected %0d", r.len, FRAME_LEN); end
    n_checks++;
    if (r.rf_cnt != 1) begin n_fail++; $display("FAIL basic_r_finish_count: got %0d, expected 1", r.rf_cnt); end
    n_checks++;
    if (r.rf_cyc - r.last_rise < 1 || r.rf_cyc - r.last_rise > 4 || r.rf_cyc >= r.len) begin
      n_fail++;
      $display("FAIL basic_r_finish_timing: r_finish cycle %0d, last rise %0d, finish %0d, expected lag 1..4 before finish",
               r.rf_cyc, r.last_rise, r.len);
    end
    last_word = d;
    n_checks++;
    if (bus.data_o !== last_word) begin n_fail++; $display("FAIL basic_data_o: got %h, expected %h", bus.data_o, last_word); end
  endtask

  task automatic test_back_to_back();
    frame_t       r;
    logic [W-1:0] d;
    repeat (2) @(negedge clk);
    d = W'(8'h44);
    do_frame(d, 0, 0, r);
    last_word = d;
    n_checks++;
    if (r.timeout || bus.data_o !== last_word || r.len != FRAME_LEN) begin
      n_fail++;
      $display("FAIL b2b_gap2: data_o %h len %0d timeout %0d, expected %h len %0d", bus.data_o, r.len, r.timeout, last_word, FRAME_LEN);
    end
    d = W'($urandom);
    do_frame(d, 0, 0, r);
    last_word = d;
    n_checks++;
    if (r.timeout || bus.data_o !== last_word || r.len != FRAME_LEN || r.bits !== d) begin
      n_fail++;
      $display("FAIL b2b_gap0: data_o %h bits %h len %0d, expected %h len %0d", bus.data_o, r.bits, r.len, last_word, FRAME_LEN);
    end
  endtask

  task automatic test_ignore_start();
    frame_t       r;
    logic [W-1:0] d = W'(8'h35);
    @(negedge clk);
    do_frame(d, 1, 30, r);
    last_word = d;
    n_checks++;
    if (r.bits !== d || bus.data_o !== last_word) begin
      n_fail++;
      $display("FAIL ignore_start_data: mosi %h data_o %h, expected %h", r.bits, bus.data_o, d);
    end
    n_checks++;
    if (r.len != FRAME_LEN || r.fin_w != 1 || r.rf_cnt != 1) begin
      n_fail++;
      $display("FAIL ignore_start_timing: len %0d finish %0d r_finish %0d, expected %0d 1 1", r.len, r.fin_w, r.rf_cnt, FRAME_LEN);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_t   r;
    int       rises = 0, pulses = 0, cyc = 0;
    logic     prev  = 1'b0;
    logic [2:0] got;
    @(negedge clk);
    bus.data_i = W'(8'h5A);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (rises < 4 && cyc < 4 * FRAME_LEN) begin
      if (bus.sclk && !prev) rises++;
      prev = bus.sclk;
      if (bus.finish || bus.r_finish) pulses++;
      if (rises < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    n_checks++;
    if (rises != 4) begin n_fail++; $display("FAIL midreset_reach: got %0d rises, expected 4", rises); end
    rst_n = 1'b0;
    #1;
    got = {bus.ss_n, bus.sclk, bus.mosi};
    n_checks++;
    if (got !== 3'b100 || bus.data_o !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: ss_n/sclk/mosi %b data_o %h, expected 100 and 00", got, bus.data_o);
    end
    last_word = '0;
    repeat (2) begin
      @(negedge clk);
      if (bus.finish || bus.r_finish) pulses++;
    end
    rst_n = 1'b1;
    repeat (FRAME_LEN) begin
      @(negedge clk);
      if (bus.finish || bus.r_finish) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL midreset_no_pulses: got %0d pulses, expected 0", pulses); end
    do_frame(W'(8'hFF), 0, 0, r);
    last_word = W'(8'hFF);
    n_checks++;
    if (r.timeout || bus.data_o !== last_word || r.rf_cnt != 1) begin
      n_fail++;
      $display("FAIL midreset_recover: data_o %h r_finish %0d, expected %h 1", bus.data_o, r.rf_cnt, last_word);
    end
  endtask

  task automatic test_patterns();
    frame_t       r;
    logic [W-1:0] pats [0:6];
    pats[0] = W'(8'h00);
    pats[1] = W'(8'h80);
    pats[2] = W'(8'h01);
    for (int i = 3; i < 7; i++) pats[i] = W'($urandom);
    for (int i = 0; i < 7; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_frame(pats[i], 0, 0, r);
      last_word = pats[i];
      n_checks++;
      if (r.timeout || bus.data_o !== last_word || r.bits !== pats[i]) begin
        n_fail++;
        $display("FAIL pattern_%0d_data: data_o %h mosi %h, expected %h", i, bus.data_o, r.bits, pats[i]);
      end
      n_checks++;
      if (r.len != FRAME_LEN || r.fin_w != 1 || r.rf_cnt != 1) begin
        n_fail++;
        $display("FAIL pattern_%0d_timing: len %0d finish %0d r_finish %0d, expected %0d 1 1", i, r.len, r.fin_w, r.rf_cnt, FRAME_LEN);
      end
    end
  endtask

  task automatic test_slave_rearm();
    frame_t       r;
    logic [W-1:0] prev_word, d;
    prev_word = last_word;
    d         = ~prev_word;
    @(negedge clk);
    do_frame(d, 2, 30, r);
    n_checks++;
    if (r.rf_cnt != 0 || bus.data_o !== prev_word) begin
      n_fail++;
      $display("FAIL rearm_discard: r_finish %0d data_o %h, expected 0 and %h", r.rf_cnt, bus.data_o, prev_word);
    end
    n_checks++;
    if (r.len != FRAME_LEN || r.fin_w != 1 || r.bits !== d) begin
      n_fail++;
      $display("FAIL rearm_master: len %0d finish %0d mosi %h, expected %0d 1 %h", r.len, r.fin_w, r.bits, FRAME_LEN, d);
    end
    d = W'($urandom);
    do_frame(d, 0, 0, r);
    last_word = d;
    n_checks++;
    if (bus.data_o !== last_word || r.rf_cnt != 1) begin
      n_fail++;
      $display("FAIL rearm_recover: data_o %h r_finish %0d, expected %h 1", bus.data_o, r.rf_cnt, last_word);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_frame();
    test_patterns();
    test_slave_rearm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
